// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and RX state encoding for the UART echo path
package uart_pkg;

  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_BAUD        = 115_200;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit-period counter with one-cycle tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLK_FREQ_HZ / DEF_BAUD,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] baud_cnt_o,
  output logic             baud_tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign baud_tick_o = (cnt_q == CNT_LAST);
  assign baud_cnt_o  = cnt_q;

  // Next count: wrap to zero on the last clock of each bit period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (baud_tick_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_echo_top.sv
// rtl/uart_echo_top.sv - 8-N-1 UART receiver looped back into a transmitter
module uart_echo_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic uart_rxi,
  output logic uart_txo
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic             baud_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .baud_cnt_o  (baud_cnt),
    .baud_tick_o (baud_tick)
  );

  logic rx_meta_q, rx_sync_q;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxi;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e              state, state_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [2:0]             bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_d;
  logic [DATA_BITS-1:0]   rx_data, rx_data_d;
  logic                   rx_done, rx_done_d;
  logic                   rx_ferr_q, rx_ferr_d;

  // RX state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RX_IDLE;
      rx_cnt_q  <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      state     <= state_d;
      rx_cnt_q  <= rx_cnt_d;
      bit_idx   <= bit_idx_d;
      rx_shift  <= rx_shift_d;
      rx_data   <= rx_data_d;
      rx_done   <= rx_done_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  // RX next state: mid-bit sampling, LSB first; a low stop bit parks in
  // RX_STOP (ferr set) until the line returns high, without rx_done.
  always_comb begin
    state_d    = state;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    bit_idx_d  = bit_idx;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_done_d  = 1'b0;
    rx_ferr_d  = rx_ferr_q;
    case (state)
      RX_IDLE: begin
        rx_cnt_d  = '0;
        rx_ferr_d = 1'b0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift[DATA_BITS-1:1]};
          bit_idx_d  = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_ferr_q) begin
          rx_cnt_d = rx_cnt_q;
          if (rx_sync_q) state_d = RX_IDLE;
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_data_d = rx_shift;
            rx_done_d = 1'b1;
            state_d   = RX_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  logic                  tx_busy;
  logic [3:0]            tx_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic                  tx_reg;
  logic                  tx_free;

  // The tick that retires the stop-bit tail also frees TX for a byte
  // completing on that same cycle, so 11-bit RX spacing never loses a byte.
  assign tx_free = !tx_busy || (tx_cnt == 4'd0 && baud_tick);

  // TX: load a frame on rx_done when free, then shift one bit per baud tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_shift <= '1;
      tx_reg   <= 1'b1;
    end else if (rx_done && tx_free) begin
      tx_shift <= {1'b1, rx_data, 1'b0};
      tx_cnt   <= 4'(FRAME_BITS);
      tx_busy  <= 1'b1;
    end else if (tx_busy && baud_tick) begin
      if (tx_cnt != 4'd0) begin
        tx_reg   <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
        tx_cnt   <= tx_cnt - 1'b1;
      end else begin
        tx_busy <= 1'b0;
      end
    end
  end

  assign uart_txo = tx_reg;

endmodule

// File: tb/tb_uart_echo_top.sv
// tb/tb_uart_echo_top.sv - randomized echo bench with a frame-level reference model
module tb_uart_echo_top;
  import uart_pkg::*;

  localparam int CLK_HZ = 7_372_800;
  localparam int BAUD_R = 115_200;
  localparam int CPB    = CLK_HZ / BAUD_R;

  logic clk_i = 1'b0;
  logic rst_i;
  logic uart_rxi;
  logic uart_txo;

  always #5 clk_i = ~clk_i;

  uart_echo_top #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_R)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .uart_rxi (uart_rxi),
    .uart_txo (uart_txo)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] echo_q[$];
  logic [7:0] rxd_q[$];
  logic [7:0] exp_echo[$];
  logic [7:0] exp_rxd[$];
  int         last_t0;
  bit         have_last;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Reference model: a frame whose stop bit reaches mid-bit high is received;
  // it is echoed only if at least 11 bit times passed since the last echoed frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int stop_clks, input int idle_clks);
    int t0;
    t0 = cyc;
    if (stop_v && stop_clks > CPB / 2 + 4) begin
      exp_rxd.push_back(b);
      if (!have_last || (t0 - last_t0) >= 11 * CPB) begin
        exp_echo.push_back(b);
        last_t0   = t0;
        have_last = 1'b1;
      end
    end
    uart_rxi = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxi = b[i];
      wait_clks(CPB);
    end
    uart_rxi = stop_v;
    wait_clks(stop_clks);
    uart_rxi = 1'b1;
    wait_clks(idle_clks);
  endtask

  task automatic drain_and_compare(input string tag);
    wait_clks(14 * CPB);
    check({tag, "_echo_n"}, 32'(echo_q.size()), 32'(exp_echo.size()));
    for (int i = 0; i < exp_echo.size() && i < echo_q.size(); i++)
      check({tag, "_echo"}, 32'(echo_q[i]), 32'(exp_echo[i]));
    check({tag, "_rxdone_n"}, 32'(rxd_q.size()), 32'(exp_rxd.size()));
    for (int i = 0; i < exp_rxd.size() && i < rxd_q.size(); i++)
      check({tag, "_rxdata"}, 32'(rxd_q[i]), 32'(exp_rxd[i]));
    echo_q.delete();
    rxd_q.delete();
    exp_echo.delete();
    exp_rxd.delete();
  endtask

  initial begin : rx_done_monitor
    forever begin
      @(negedge clk_i);
      if (dut.rx_done === 1'b1) rxd_q.push_back(dut.rx_data);
    end
  end

  // Decodes frames on uart_txo at mid-bit; a frame cut by reset is discarded.
  initial begin : tx_monitor
    logic [7:0] mb;
    logic       mabort;
    logic       mstop;
    forever begin
      @(negedge clk_i);
      if (!rst_i && uart_txo === 1'b0) begin
        mabort = 1'b0;
        for (int k = 0; k < CPB / 2; k++) begin
          @(negedge clk_i);
          if (rst_i) mabort = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk_i);
            if (rst_i) mabort = 1'b1;
          end
          mb[i] = uart_txo;
        end
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk_i);
          if (rst_i) mabort = 1'b1;
        end
        mstop = uart_txo;
        if (!mabort) begin
          echo_q.push_back(mb);
          check("echo_stop_bit", 32'(mstop), 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] dir_bytes [5];
    dir_bytes = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h41};
    have_last = 1'b0;
    last_t0   = 0;
    rst_i     = 1'b1;
    uart_rxi  = 1'b1;

    wait_clks(20);
    check("rst_txo", 32'(uart_txo), 32'd1);
    check("rst_state", 32'(dut.state), 32'(RX_IDLE));
    check("rst_tx_busy", 32'(dut.tx_busy), 32'd0);
    check("rst_tx_shift", 32'(dut.tx_shift), 32'h3FF);
    check("rst_tx_cnt", 32'(dut.tx_cnt), 32'd0);
    check("rst_rx_data", 32'(dut.rx_data), 32'd0);
    check("rst_baud_cnt", 32'(dut.baud_cnt), 32'd0);
    rst_i = 1'b0;
    wait_clks(5000);
    check("idle_txo", 32'(uart_txo), 32'd1);

    for (int i = 0; i < 5; i++) send_frame(dir_bytes[i], 1'b1, CPB, CPB);
    drain_and_compare("directed");

    for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, CPB, CPB);
    drain_and_compare("random");

    uart_rxi = 1'b0;
    wait_clks(20);
    uart_rxi = 1'b1;
    wait_clks(CPB);
    check("glitch_state", 32'(dut.state), 32'(RX_IDLE));
    drain_and_compare("glitch");

    send_frame(8'h3C, 1'b0, CPB, CPB);
    send_frame(8'h5A, 1'b1, CPB, CPB);
    drain_and_compare("framing");

    send_frame(8'h96, 1'b1, CPB, 0);
    uart_rxi = 1'b0;
    wait_clks(CPB);
    uart_rxi = 1'b1;
    wait_clks(CPB);
    uart_rxi = 1'b0;
    wait_clks(CPB);
    uart_rxi = 1'b1;
    wait_clks(CPB);
    check("pre_rst_tx_busy", 32'(dut.tx_busy), 32'd1);
    check("pre_rst_state", 32'(dut.state), 32'(RX_DATA));
    rst_i = 1'b1;
    wait_clks(1);
    check("midrst_txo", 32'(uart_txo), 32'd1);
    check("midrst_tx_busy", 32'(dut.tx_busy), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(RX_IDLE));
    rst_i    = 1'b0;
    uart_rxi = 1'b1;
    wait_clks(14 * CPB);
    check("midrst_no_echo", 32'(echo_q.size()), 32'd0);
    check("midrst_rxdone_n", 32'(rxd_q.size()), 32'd1);
    if (rxd_q.size() > 0) check("midrst_rxdata", 32'(rxd_q[0]), 32'h96);
    echo_q.delete();
    rxd_q.delete();
    exp_echo.delete();
    exp_rxd.delete();
    have_last = 1'b0;
    send_frame(8'hC3, 1'b1, CPB, CPB);
    drain_and_compare("after_rst");

    send_frame(8'h3E, 1'b1, CPB * 11 / 16, 0);
    send_frame(8'hE7, 1'b1, CPB, CPB);
    drain_and_compare("overrun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
